// File: rtl/layer0_input_quantizer_pkg.sv
// Shared constants, state encoding and code-mapping limits for the layer-0
// input quantizer.
package layer0_input_quantizer_pkg;

  localparam int SAMPLE_W  = 16;  // signed width of each I and Q sample
  localparam int NUM_BINS  = 8;   // time bins per trace
  localparam int BIN_LEN   = 16;  // samples per bin (power of two, >= 2)
  localparam int FEAT_BITS = 2;   // code width per feature
  localparam int SHIFT     = 9;   // arithmetic shift applied to the bin mean

  localparam int LOG2_BIN  = $clog2(BIN_LEN);
  localparam int ACC_W     = SAMPLE_W + $clog2(BIN_LEN);
  localparam int OUT_W     = 2 * NUM_BINS * FEAT_BITS;
  localparam int BIN_CNT_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

  // Code mapping: offset recentres the signed mean, max is the clamp ceiling.
  localparam int CODE_OFFSET = 2 ** (FEAT_BITS - 1);
  localparam int CODE_MAX    = (2 ** FEAT_BITS) - 1;

  typedef enum logic [1:0] {
    ACCUM      = 2'd0,
    HOLD       = 2'd1,
    HOLD_DRAIN = 2'd2,
    DRAIN      = 2'd3
  } state_e;

endpackage

// File: rtl/layer0_input_quantizer_feature_code_map.sv
// Maps one bin accumulator total to a small unsigned feature code:
// mean, arithmetic shift, offset, then clamp into [0, CODE_MAX].
module layer0_input_quantizer_feature_code_map
  import layer0_input_quantizer_pkg::*;
(
  input  logic signed [ACC_W-1:0]     acc_total,
  output logic        [FEAT_BITS-1:0] code
);

  localparam logic signed [ACC_W-1:0] OFF_S = ACC_W'(CODE_OFFSET);
  localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(CODE_MAX);

  logic signed [ACC_W-1:0] mean;
  logic signed [ACC_W-1:0] scaled;
  logic signed [ACC_W-1:0] v;

  assign mean   = acc_total >>> LOG2_BIN;
  assign scaled = mean >>> SHIFT;
  assign v      = scaled + OFF_S;

  // Clamp the offset value into the code range.
  always_comb begin
    code = '0;
    if (v < 0) begin
      code = '0;
    end else if (v > MAX_S) begin
      code = FEAT_BITS'(CODE_MAX);
    end else begin
      code = v[FEAT_BITS-1:0];
    end
  end

endmodule

// File: rtl/layer0_input_quantizer.sv
// Boxcar-averages a streamed I/Q trace over fixed bins, quantizes each bin
// mean to a feature code and presents the packed vector to the layer-0
// neurons through a held valid/ready output register.
//
// Handshakes: an input sample transfers on a cycle where s_valid && s_ready;
// the feature vector transfers on a cycle where m_valid && m_ready. While
// m_valid=1 && m_ready=0, m_valid and m_data hold steady.
module layer0_input_quantizer
  import layer0_input_quantizer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [SAMPLE_W-1:0] s_i,
  input  logic signed [SAMPLE_W-1:0] s_q,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic        [OUT_W-1:0]    m_data,
  output logic                       err_short,
  output logic        [1:0]          dbg_state
);

  state_e state, state_next;

  logic signed [ACC_W-1:0]     acc_i, acc_q;
  logic signed [ACC_W-1:0]     ext_i, ext_q;
  logic signed [ACC_W-1:0]     sum_i, sum_q;
  logic        [LOG2_BIN-1:0]  samp_cnt;
  logic        [BIN_CNT_W-1:0] bin_cnt;
  logic        [OUT_W-1:0]     stage, stage_next;
  logic        [FEAT_BITS-1:0] code_i, code_q;

  logic xfer;
  logic accum_xfer;
  logic bin_close;
  logic final_xfer;
  logic early_last;

  assign dbg_state = state;

  assign xfer       = s_valid && s_ready;
  assign accum_xfer = xfer && (state == ACCUM);
  assign bin_close  = accum_xfer && (samp_cnt == LOG2_BIN'(BIN_LEN - 1));
  assign final_xfer = bin_close && (bin_cnt == BIN_CNT_W'(NUM_BINS - 1));
  assign early_last = accum_xfer && s_last && !final_xfer;

  // Running totals include the sample transferring this cycle so a bin can
  // close on its last sample without an extra cycle.
  assign ext_i = {{(ACC_W - SAMPLE_W){s_i[SAMPLE_W-1]}}, s_i};
  assign ext_q = {{(ACC_W - SAMPLE_W){s_q[SAMPLE_W-1]}}, s_q};
  assign sum_i = acc_i + ext_i;
  assign sum_q = acc_q + ext_q;

  layer0_input_quantizer_feature_code_map u_map_i (
    .acc_total (sum_i),
    .code      (code_i)
  );

  layer0_input_quantizer_feature_code_map u_map_q (
    .acc_total (sum_q),
    .code      (code_q)
  );

  // Drop the new I/Q codes into the staging vector slot of the current bin.
  always_comb begin
    stage_next = stage;
    for (int b = 0; b < NUM_BINS; b++) begin
      if (bin_cnt == BIN_CNT_W'(b)) begin
        stage_next[FEAT_BITS*(2*b)   +: FEAT_BITS] = code_i;
        stage_next[FEAT_BITS*(2*b+1) +: FEAT_BITS] = code_q;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    state_next = state;
    s_ready    = 1'b1;
    m_valid    = 1'b0;
    case (state)
      ACCUM: begin
        if (final_xfer) begin
          state_next = s_last ? HOLD : HOLD_DRAIN;
        end
      end
      HOLD: begin
        s_ready = 1'b0;
        m_valid = 1'b1;
        if (m_ready) begin
          state_next = ACCUM;
        end
      end
      HOLD_DRAIN: begin
        m_valid = 1'b1;
        // Output accepted and trace ended together: nothing left to drain.
        if (m_ready) begin
          state_next = (s_valid && s_last) ? ACCUM : DRAIN;
        end else if (s_valid && s_last) begin
          state_next = HOLD;
        end
      end
      DRAIN: begin
        if (s_valid && s_last) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // Accumulators, counters, staging/output registers and the short-trace flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_i     <= '0;
      acc_q     <= '0;
      samp_cnt  <= '0;
      bin_cnt   <= '0;
      stage     <= '0;
      m_data    <= '0;
      err_short <= 1'b0;
    end else begin
      err_short <= early_last;
      if (early_last) begin
        acc_i    <= '0;
        acc_q    <= '0;
        samp_cnt <= '0;
        bin_cnt  <= '0;
      end else if (bin_close) begin
        acc_i    <= '0;
        acc_q    <= '0;
        samp_cnt <= '0;
        stage    <= stage_next;
        if (final_xfer) begin
          bin_cnt <= '0;
          m_data  <= stage_next;
        end else begin
          bin_cnt <= bin_cnt + 1'b1;
        end
      end else if (accum_xfer) begin
        acc_i    <= sum_i;
        acc_q    <= sum_q;
        samp_cnt <= samp_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_layer0_input_quantizer.sv
// Directed bench for layer0_input_quantizer: table of constant-trace vectors
// plus hand-written sequences for hold, short trace, long trace, drain and
// reset corner cases.
module tb_layer0_input_quantizer;

  logic               clk;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_i;
  logic signed [15:0] s_q;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic [31:0]        m_data;
  logic               err_short;
  logic [1:0]         dbg_state;

  int n_checks;
  int n_fail;

  typedef struct {
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic [31:0]        exp;
  } vec_t;

  vec_t vecs[7];

  layer0_input_quantizer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_i       (s_i),
    .s_q       (s_q),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err_short (err_short),
    .dbg_state (dbg_state)
  );

  // Clock and reset defaults.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one sample and wait (bounded) for it to transfer.
  task automatic send_sample(input logic signed [15:0] i, input logic signed [15:0] q,
                             input logic last);
    int waited;
    s_i     = i;
    s_q     = q;
    s_last  = last;
    s_valid = 1'b1;
    waited  = 0;
    while (!s_ready && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Send n constant samples; last_at (1-based) marks s_last, 0 for none.
  task automatic send_trace(input int n, input logic signed [15:0] i,
                            input logic signed [15:0] q, input int last_at);
    for (int k = 1; k <= n; k++) begin
      send_sample(i, q, (k == last_at));
    end
  endtask

  // Wait (bounded) for m_valid, compare the vector, accept it.
  task automatic take_output(input string name, input logic [31:0] exp);
    int waited;
    waited = 0;
    while (!m_valid && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check({name, "_valid"}, 32'(m_valid), 32'd1);
    check({name, "_data"}, m_data, exp);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check({name, "_drop"}, 32'(m_valid), 32'd0);
    check({name, "_sready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_i      = '0;
    s_q      = '0;
    s_last   = 1'b0;
    m_ready  = 1'b0;

    // I code / Q code per bin -> nibble {Q,I}.
    vecs[0] = '{i: 16'sd1000,   q: -16'sd1000,  exp: 32'h3333_3333}; // 3/0
    vecs[1] = '{i: 16'sd0,      q: 16'sd0,      exp: 32'hAAAA_AAAA}; // 2/2
    vecs[2] = '{i: 16'sd32767,  q: -16'sd32768, exp: 32'h3333_3333}; // clamp 3/0
    vecs[3] = '{i: 16'sd300,    q: -16'sd300,   exp: 32'h6666_6666}; // 2/1
    vecs[4] = '{i: -16'sd300,   q: 16'sd300,    exp: 32'h9999_9999}; // 1/2
    vecs[5] = '{i: -16'sd513,   q: 16'sd511,    exp: 32'h8888_8888}; // 0/2
    vecs[6] = '{i: 16'sd512,    q: -16'sd512,   exp: 32'h7777_7777}; // 3/1

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_data", m_data, 32'd0);
    check("rst_err_short", 32'(err_short), 32'd0);
    rst = 1'b0;

    // Table-driven constant traces, 128 samples, s_last on the final one.
    for (int v = 0; v < 7; v++) begin
      send_trace(128, vecs[v].i, vecs[v].q, 128);
      check($sformatf("vec%0d_latency", v), 32'(m_valid), 32'd1);
      check($sformatf("vec%0d_hold_sready", v), 32'(s_ready), 32'd0);
      take_output($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Per-bin ramp: bin b I=(b-4)*512 -> codes 0,0,0,1,2,3,3,3; Q=0 -> 2.
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 16; k++) begin
        send_sample(16'((b - 4) * 512), 16'sd0, (b == 7 && k == 15));
      end
    end
    take_output("ramp", 32'hBBBA_9888);

    // Long hold with m_ready low: output and s_ready must not move.
    send_trace(128, 16'sd0, 16'sd0, 128);
    held = m_data;
    check("hold_data", held, 32'hAAAA_AAAA);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check("hold_stable", m_data, held);
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_sready", 32'(s_ready), 32'd0);
    end
    take_output("hold_release", 32'hAAAA_AAAA);

    // Short trace: s_last on sample 50.
    send_trace(50, 16'sd1000, -16'sd1000, 50);
    check("short_err_pulse", 32'(err_short), 32'd1);
    check("short_no_valid", 32'(m_valid), 32'd0);
    @(posedge clk);
    #1;
    check("short_err_single", 32'(err_short), 32'd0);
    check("short_no_valid2", 32'(m_valid), 32'd0);
    send_trace(128, 16'sd0, 16'sd0, 128);
    take_output("after_short", 32'hAAAA_AAAA);

    // 140-sample trace: output after 128, samples 129..140 discarded.
    send_trace(128, 16'sd1000, -16'sd1000, 0);
    check("long_valid", 32'(m_valid), 32'd1);
    check("long_sready", 32'(s_ready), 32'd1);
    send_trace(12, -16'sd20000, 16'sd20000, 12);
    check("long_still_valid", 32'(m_valid), 32'd1);
    check("long_blocked", 32'(s_ready), 32'd0);
    take_output("long", 32'h3333_3333);
    send_trace(128, 16'sd300, -16'sd300, 128);
    take_output("after_long", 32'h6666_6666);

    // Output accepted before s_last: remaining samples drained silently.
    send_trace(128, 16'sd0, 16'sd0, 0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("drain_valid_drop", 32'(m_valid), 32'd0);
    check("drain_state", 32'(dbg_state), 32'd3);
    send_trace(7, 16'sd1000, 16'sd1000, 7);
    check("drain_no_valid", 32'(m_valid), 32'd0);
    check("drain_no_err", 32'(err_short), 32'd0);
    send_trace(128, 16'sd1000, -16'sd1000, 128);
    take_output("after_drain", 32'h3333_3333);

    // Reset mid-bin.
    send_trace(20, 16'sd1000, 16'sd1000, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstmid_valid", 32'(m_valid), 32'd0);
    check("rstmid_sready", 32'(s_ready), 32'd1);
    send_trace(128, 16'sd300, -16'sd300, 128);
    take_output("after_rstmid", 32'h6666_6666);

    // Reset during HOLD.
    send_trace(128, 16'sd1000, -16'sd1000, 128);
    check("rsthold_pre_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rsthold_valid", 32'(m_valid), 32'd0);
    check("rsthold_sready", 32'(s_ready), 32'd1);
    check("rsthold_data", m_data, 32'd0);
    send_trace(128, 16'sd0, 16'sd0, 128);
    take_output("after_rsthold", 32'hAAAA_AAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer0_input_quantizer.md
Name: layer0_input_quantizer

Overview:
Upstream front end for the layer-0 LUT neurons in the readout classifier. It takes a streamed I/Q readout trace and boxcar-averages it over fixed time bins. Each bin average is quantized to a small unsigned code, and the packed feature vector is presented to the layer-0 fan-in wiring. It sits between the demodulated ADC stream and the combinational layer-0 neuron array. Output is held in a register with a valid/ready handshake.

Parameters:
SAMPLE_W, 16, signed width of each I and Q sample
NUM_BINS, 8, time bins per trace
BIN_LEN, 16, samples per bin; power of two, at least 2
FEAT_BITS, 2, code width per feature
SHIFT, 9, arithmetic right shift applied to the bin mean before code mapping

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  input sample ready
s_i  in  SAMPLE_W  signed I sample
s_q  in  SAMPLE_W  signed Q sample
s_last  in  1  marks the final sample of a trace
m_valid  out  1  feature vector valid
m_ready  in  1  downstream accepts the feature vector
m_data  out  2*NUM_BINS*FEAT_BITS  packed codes
err_short  out  1  one-cycle pulse when a trace ends early

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. Reset clears all state to ACCUM. Reset values: s_ready=1, m_valid=0, m_data=0, err_short=0. Reset mid-trace or mid-hold discards everything.
- Sample transfer: occurs when s_valid && s_ready.
- Accumulators: two signed accumulators, each SAMPLE_W+log2(BIN_LEN) bits wide; they cannot overflow. Counters: sample counter 0..BIN_LEN-1 and bin counter 0..NUM_BINS-1.
- Bin close: when a transfer lands on sample index BIN_LEN-1, the bin closes. That same cycle:
  - mean = acc_total >>> log2(BIN_LEN), arithmetic shift.
  - v = (mean >>> SHIFT) + 2^(FEAT_BITS-1), clamped to [0, 2^FEAT_BITS-1].
  - The code is written into the staging vector, the accumulator reloads to zero, and the bin counter increments.
- Packing: bin b I code goes to bits [FEAT_BITS*2b +: FEAT_BITS]; Q code goes to [FEAT_BITS*(2b+1) +: FEAT_BITS].
- State ACCUM: s_ready=1.
  - Closing the last bin copies staging into m_data and asserts m_valid on the next cycle, so latency is 1 cycle after the final transfer.
  - If that final transfer has s_last=1, go to HOLD. Otherwise go to HOLD_DRAIN.
- State HOLD: s_ready=0, m_valid=1, m_data stable. When m_ready=1, m_valid drops the next cycle and the state returns to ACCUM with counters zeroed.
- State HOLD_DRAIN: same as HOLD, except s_ready=1 and incoming samples are discarded.
  - If s_last is seen before m_ready, go to HOLD.
  - If m_ready arrives first, go to DRAIN.
- State DRAIN: s_ready=1, m_valid=0, samples discarded. A transfer with s_last=1 returns to ACCUM.
- Early s_last: s_last on a transfer that is not the final sample of the final bin discards the partial trace. It pulses err_short the following cycle and returns to ACCUM with counters and accumulators zeroed. No output is produced.
- Simultaneous events: m_ready during HOLD has no input interaction, because s_ready=0. m_ready in the same cycle m_valid rises is honoured, giving minimum hold of 1 cycle. Back-to-back throughput is one trace per NUM_BINS*BIN_LEN+1 cycles.
- Handshake rule: m_data and m_valid must not change while m_valid=1 && m_ready=0.

Decomposition:
- Shared package holds:
  - state enum {ACCUM, HOLD, HOLD_DRAIN, DRAIN}
  - localparam ACC_W = SAMPLE_W + $clog2(BIN_LEN)
  - localparam OUT_W = 2*NUM_BINS*FEAT_BITS
  - code mapping constants: offset 2^(FEAT_BITS-1) and max 2^FEAT_BITS-1
- One sub-module, feature_code_map: combinational mean, shift, offset and clamp, instantiated twice (I and Q).

Test Plan:
- Constant I=1000, Q=-1000 for 128 samples with s_last on sample 128 -> m_valid 1 cycle later, m_data=32'h3333_3333 (I code 3, Q code 0 per bin).
- All samples 0 -> every code is 2, m_data=32'hAAAA_AAAA. Hold m_ready=0 for 20 cycles -> m_data stable, s_ready=0 throughout.
- I=32767, Q=-32768 -> clamp gives I=3, Q=0, m_data=32'h3333_3333. I=300, Q=-300 -> I=2 (0+2), Q=1 (-1+2), m_data=32'h6666_6666.
- s_last on sample 50 -> err_short pulses once, no m_valid. Next full trace of zeros -> 32'hAAAA_AAAA.
- 140-sample trace, s_last on sample 140 -> output after sample 128, samples 129..140 discarded. Next trace is decoded correctly.
- rst asserted mid-bin and during HOLD -> next cycle m_valid=0, s_ready=1; next full trace decodes correctly.
